bcd_conv_sched: RTL
===================

Name: bcd_conv_sched

Overview:
- Shared, sequential shift-add-3 (double-dabble) binary-to-BCD engine serving two requesters, e.g. the operand display and the subtractor-result display.
- Round-robin arbitration between the two; converts one bit per clock.
- Presents a registered packed-BCD result tagged with the requester ID.
- Replaces the need for two combinational converters in front of the 7-segment decoders.

Parameters:
- N, 6, input binary width (bits).
- DIGITS, 2, number of BCD output digits. Elaboration must fail unless 2^N-1 <= 10^DIGITS-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  level request per requester; bit i = requester i.
- bin0  in  N  value of requester 0, sampled only at grant.
- bin1  in  N  value of requester 1, sampled only at grant.
- grant  out  2  one-hot, 1-cycle pulse on the cycle a request is accepted.
- busy  out  1  high from the cycle after grant until done is high.
- done  out  1  1-cycle pulse; bcd_out/done_id valid and held until the next done.
- done_id  out  1  requester index of the current bcd_out.
- bcd_out  out  4*DIGITS  packed BCD result, digit 0 (units) in bits [3:0].

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; grant=0, busy=0, done=0, done_id=0, bcd_out=0; RR pointer=0.
  - Reset asserted mid-conversion aborts it; no done is produced for the aborted request.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If req!=0, choose a requester. If only one is requesting, choose it. If both, choose the one not served last; after reset, requester 0 wins.
  - On that edge: latch bin of the winner into an N-bit shift register, clear the DIGITS*4-bit BCD accumulator, bit counter=N, grant[winner]=1 for one cycle, store the winner ID, go to SHIFT.
  - If req=0, stay in IDLE; all pulses stay 0.
- SHIFT (exactly N cycles):
  - Each edge, first add 3 to every accumulator digit >=5 (all digits in parallel, 4-bit wrap-free since digit<=9).
  - Then shift {accumulator, shiftreg} left by 1; the shiftreg MSB enters digit 0 LSB.
  - Decrement the counter. On the edge where the counter reaches 0, go to DONE and load bcd_out from the post-shift accumulator and done_id from the stored ID.
- DONE (1 cycle): done=1, busy=0. Next edge goes to IDLE and updates the RR pointer to the served ID.
- Latency: grant at edge k; done high in the cycle after edge k+N; next grant no earlier than edge k+N+2. Throughput is one conversion per N+2 cycles.
- Requests are level-sensitive, not queued:
  - A requester that keeps req high is re-served when next granted.
  - Changes to req or bin during SHIFT/DONE are ignored.
  - Dropping req after grant does not cancel the conversion.
- bcd_out and done_id change only on entry to DONE or on reset.
- grant, done and busy are mutually exclusive in any cycle.

Test Plan:
- Reset, then req=01 with bin0=45 held 1 cycle -> grant=01 at edge k; busy for 6 cycles; done=1 with bcd_out=8'h45, done_id=0 in the cycle after edge k+6; bcd_out holds afterwards.
- req=11 held continuously, bin0=12, bin1=63 -> results alternate 8'h12/id0, 8'h63/id1, 8'h12/id0...; requester 0 is served first after reset; spacing between grants is exactly 8 cycles.
- Boundaries: bin1=0 -> 8'h00; bin1=63 -> 8'h63; bin0=9 and bin0=10 -> 8'h09 and 8'h10.
- Change bin0 from 45 to 7 two cycles after grant -> result is still 8'h45. Drop req the cycle after grant -> done still occurs.
- Assert rst_n=0 during the 3rd SHIFT cycle -> all outputs 0 immediately; no done for the aborted request. After release, req=10, bin1=33 -> 8'h33, id1.
- Exhaustive sweep of 0..63 on each requester, scoreboarded against a behavioural div/mod-10 model. Repeat with N=8, DIGITS=3 (255 -> 12'h255).

Source files
------------

// File: rtl/bcd_conv_sched_if.sv
// Request/result bundle for the shared binary-to-BCD converter.
//   req      : level request per requester (bit i = requester i)
//   bin0/1   : binary operand of each requester, sampled at grant
//   grant    : one-hot accept pulse
//   busy     : conversion in progress
//   done     : result-valid pulse
//   done_id  : requester that owns bcd_out
//   bcd_out  : packed BCD result, units digit in [3:0]
// The master modport is the requester side; the slave modport is the converter.
interface bcd_conv_sched_if #(
    parameter int N      = 6,
    parameter int DIGITS = 2
);
    logic [1:0]          req;
    logic [N-1:0]        bin0;
    logic [N-1:0]        bin1;
    logic [1:0]          grant;
    logic                busy;
    logic                done;
    logic                done_id;
    logic [4*DIGITS-1:0] bcd_out;

    modport master (
        output req, bin0, bin1,
        input  grant, busy, done, done_id, bcd_out
    );

    modport slave (
        input  req, bin0, bin1,
        output grant, busy, done, done_id, bcd_out
    );
endinterface

// File: rtl/bcd_conv_sched.sv
// Shared sequential double-dabble converter for two requesters.
// Round-robin arbitration, one input bit converted per clock, registered
// packed-BCD result tagged with the requester index.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/result bundle (slave side)
//
// state   | meaning
// S_IDLE  | waiting for a request; grant is asserted combinationally here
// S_SHIFT | N add-3/shift steps on {accumulator, shift register}
// S_DONE  | one cycle with done high; round-robin pointer advances on exit
module bcd_conv_sched #(
    parameter int N      = 6,
    parameter int DIGITS = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    bcd_conv_sched_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    localparam int BW = 4 * DIGITS;
    localparam longint unsigned BIN_MAX = (64'd1 << N) - 64'd1;
    localparam longint unsigned BCD_MAX = (64'd10 ** DIGITS) - 64'd1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    generate
        if (BIN_MAX > BCD_MAX) begin : g_width_check
            $error("bcd_conv_sched: DIGITS too small for N-bit input");
        end
    endgenerate

    logic [1:0]    state;
    logic [N-1:0]  sr;
    logic [BW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          cur_id;
    logic          rr_ptr;      // requester preferred when both request
    logic          win;
    logic [BW-1:0] acc_adj;
    logic [BW-1:0] acc_nxt;
    logic [N-1:0]  sr_nxt;
    logic [BW-1:0] bcd_q;
    logic          id_q;

    always_comb begin
        win = bus.req[1];
        if (bus.req == 2'b11) begin
            win = rr_ptr;
        end
    end

    // Grant is suppressed while reset is held so it reads 0 during reset.
    always_comb begin
        bus.grant = 2'b00;
        if (state == S_IDLE && rst_n && bus.req != 2'b00) begin
            bus.grant = win ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
        acc_nxt = {acc_adj[BW-2:0], sr[N-1]};
        sr_nxt  = {sr[N-2:0], 1'b0};
    end

    assign bus.busy    = (state == S_SHIFT);
    assign bus.done    = (state == S_DONE);
    assign bus.done_id = id_q;
    assign bus.bcd_out = bcd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            sr     <= '0;
            acc    <= '0;
            cnt    <= '0;
            cur_id <= 1'b0;
            rr_ptr <= 1'b0;
            bcd_q  <= '0;
            id_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req != 2'b00) begin
                        sr     <= win ? bus.bin1 : bus.bin0;
                        acc    <= '0;
                        cnt    <= CW'(N);
                        cur_id <= win;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc <= acc_nxt;
                    sr  <= sr_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= S_DONE;
                        bcd_q <= acc_nxt;
                        id_q  <= cur_id;
                    end
                end
                S_DONE: begin
                    rr_ptr <= ~cur_id;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
